// File: rtl/conv_encoder_tx.sv
// Rate-1/2 feedforward convolutional encoder with valid/ready input and output,
// optional zero-tail termination, and a single registered output stage.
module conv_encoder_tx #(
    parameter int         K       = 3,
    parameter logic [8:0] G0_OCT  = 9'o007,
    parameter logic [8:0] G1_OCT  = 9'o005,
    parameter bit         TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [1:0] sym,
    output logic       sym_last,
    output logic       busy
);

    localparam int M = K - 1;
    localparam logic [K-1:0] G0 = G0_OCT[K-1:0];
    localparam logic [K-1:0] G1 = G1_OCT[K-1:0];
    localparam logic [3:0] TAIL_LAST = 4'(M - 1);

    generate
        if (K < 3 || K > 9) begin : g_k_check
            $error("conv_encoder_tx: K must be within 3..9");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_TAIL = 1'b1
    } state_t;

    function automatic logic parity_f(input logic [K-1:0] v);
        return ^v;
    endfunction

    state_t         state_r, state_nxt_s;
    logic [M-1:0]   shift_r, shift_nxt_s;
    logic [3:0]     tail_cnt_r, tail_cnt_nxt_s;
    logic [1:0]     sym_r;
    logic           sym_valid_r, sym_last_r;
    logic           can_load_s, load_s, last_nxt_s, u_s;
    logic [K-1:0]   reg_s;
    logic [1:0]     sym_nxt_s;

    assign can_load_s = !sym_valid_r || sym_ready;
    assign in_ready   = (state_r == ST_DATA) && can_load_s;
    assign busy       = (state_r == ST_TAIL) || sym_valid_r;
    assign sym        = sym_r;
    assign sym_valid  = sym_valid_r;
    assign sym_last   = sym_last_r;

    // Tail bits are zero; in DATA the encoder input is the offered bit.
    assign u_s       = (state_r == ST_DATA) ? in_bit : 1'b0;
    assign reg_s     = {u_s, shift_r};
    assign sym_nxt_s = {parity_f(reg_s & G0), parity_f(reg_s & G1)};

    // Next-state, shift-register and load decisions.
    always_comb begin
        state_nxt_s    = state_r;
        shift_nxt_s    = shift_r;
        tail_cnt_nxt_s = tail_cnt_r;
        load_s         = 1'b0;
        last_nxt_s     = 1'b0;
        case (state_r)
            ST_DATA: begin
                if (in_valid && can_load_s) begin
                    load_s      = 1'b1;
                    shift_nxt_s = reg_s[K-1:1];
                    if (in_last) begin
                        if (TAIL_EN) begin
                            state_nxt_s    = ST_TAIL;
                            tail_cnt_nxt_s = 4'd0;
                        end else begin
                            last_nxt_s  = 1'b1;
                            shift_nxt_s = '0;
                        end
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_TAIL: begin
                if (can_load_s) begin
                    load_s      = 1'b1;
                    shift_nxt_s = reg_s[K-1:1];
                    if (tail_cnt_r == TAIL_LAST) begin
                        last_nxt_s     = 1'b1;
                        state_nxt_s    = ST_DATA;
                        tail_cnt_nxt_s = 4'd0;
                    end else begin
                        tail_cnt_nxt_s = tail_cnt_r + 4'd1;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s    = ST_DATA;
                shift_nxt_s    = '0;
                tail_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // State registers and the single output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_DATA;
            shift_r     <= '0;
            tail_cnt_r  <= 4'd0;
            sym_r       <= 2'b00;
            sym_valid_r <= 1'b0;
            sym_last_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            shift_r    <= shift_nxt_s;
            tail_cnt_r <= tail_cnt_nxt_s;
            if (load_s) begin
                sym_r       <= sym_nxt_s;
                sym_valid_r <= 1'b1;
                sym_last_r  <= last_nxt_s;
            end else if (sym_ready) begin
                sym_valid_r <= 1'b0;
            end else begin
                sym_valid_r <= sym_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Self-checking bench: three encoder configurations driven with directed and
// randomized frames, checked against a sequence-level reference encoder.
module tb_conv_encoder_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_valid, in_ready, in_bit, in_last;
    logic [2:0] sym_valid, sym_ready, sym_last, busy;
    logic [5:0] sym_all;

    int total  = 0;
    int passes = 0;

    bit         fbits   [0:1023];
    logic [1:0] exp_sym [0:1039];
    int         nexp;

    always #5 clk = ~clk;

    // d=0: K=3 7/5 with tail, d=1: K=3 7/5 without tail, d=2: K=7 171/133 with tail
    conv_encoder_tx #(.K(3), .G0_OCT(9'o007), .G1_OCT(9'o005), .TAIL_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_bit(in_bit[0]), .in_last(in_last[0]), .sym_valid(sym_valid[0]),
        .sym_ready(sym_ready[0]), .sym(sym_all[1:0]), .sym_last(sym_last[0]), .busy(busy[0]));

    conv_encoder_tx #(.K(3), .G0_OCT(9'o007), .G1_OCT(9'o005), .TAIL_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_bit(in_bit[1]), .in_last(in_last[1]), .sym_valid(sym_valid[1]),
        .sym_ready(sym_ready[1]), .sym(sym_all[3:2]), .sym_last(sym_last[1]), .busy(busy[1]));

    conv_encoder_tx #(.K(7), .G0_OCT(9'o171), .G1_OCT(9'o133), .TAIL_EN(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_bit(in_bit[2]), .in_last(in_last[2]), .sym_valid(sym_valid[2]),
        .sym_ready(sym_ready[2]), .sym(sym_all[5:4]), .sym_last(sym_last[2]), .busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    endtask

    // Reference: each coded bit is the XOR of tapped bits of the frame sequence
    // (current bit at tap K-1, older bits below), with zeros before the frame
    // start and as tail after it.
    function automatic void build_exp(input int n, input int k, input int g0, input int g1,
                                      input bit tail);
        nexp = n + (tail ? k - 1 : 0);
        for (int s = 0; s < nexp; s++) begin
            bit p0 = 1'b0;
            bit p1 = 1'b0;
            for (int j = 0; j < k; j++) begin
                int idx = s - (k - 1 - j);
                bit b = (idx >= 0 && idx < n) ? fbits[idx] : 1'b0;
                p0 = p0 ^ (bit'((g0 >> j) & 1) & b);
                p1 = p1 ^ (bit'((g1 >> j) & 1) & b);
            end
            exp_sym[s] = {p0, p1};
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 3'b000;
        sym_ready = 3'b111;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one frame of n bits from fbits into DUT d and check every cycle.
    task automatic run_frame(input int d, input int n, input bit tail,
                             input int rdy_pct, input int vld_pct);
        int bidx = 0;
        int sidx = 0;
        int cyc  = 0;
        bit stall_prev = 1'b0;
        logic [1:0] hs = 2'b00;
        logic hl = 1'b0;
        logic sv, ir_exp, busy_exp;
        logic [1:0] so;
        while (sidx < nexp && cyc < 40 * nexp + 100) begin
            sym_ready[d] = ($urandom_range(99) < rdy_pct);
            if (bidx < n && $urandom_range(99) < vld_pct) begin
                in_valid[d] = 1'b1;
                in_bit[d]   = fbits[bidx];
                in_last[d]  = (bidx == n - 1);
            end else begin
                in_valid[d] = 1'b0;
                in_bit[d]   = 1'($urandom_range(1));
                in_last[d]  = 1'($urandom_range(1));
            end
            #1;
            sv = sym_valid[d];
            so = sym_all[2*d +: 2];
            if (stall_prev) begin
                chk("stall_valid", 32'(sv), 32'd1);
                chk("stall_sym", 32'(so), 32'(hs));
                chk("stall_last", 32'(sym_last[d]), 32'(hl));
            end
            if (tail && bidx == n)
                ir_exp = sv && sym_ready[d] && (sidx == nexp - 1);
            else
                ir_exp = !sv || sym_ready[d];
            chk("in_ready", 32'(in_ready[d]), 32'(ir_exp));
            busy_exp = sv || (tail && bidx == n && (sidx + int'(sv)) < nexp);
            chk("busy", 32'(busy[d]), 32'(busy_exp));
            if (sv && sym_ready[d]) begin
                chk("sym", 32'(so), 32'(exp_sym[sidx]));
                chk("sym_last", 32'(sym_last[d]), 32'(sidx == nexp - 1));
                sidx++;
            end
            stall_prev = sv && !sym_ready[d];
            hs = so;
            hl = sym_last[d];
            if (in_valid[d] && in_ready[d]) bidx++;
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("frame_symbol_count", 32'(sidx), 32'(nexp));
        in_valid[d]  = 1'b0;
        sym_ready[d] = 1'b1;
        #1;
        chk("idle_valid", 32'(sym_valid[d]), 32'd0);
        chk("idle_busy", 32'(busy[d]), 32'd0);
        chk("idle_ready", 32'(in_ready[d]), 32'd1);
    endtask

    initial begin
        logic [1:0] s1 [6];
        bit         f1 [4];
        s1 = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        f1 = '{1'b1, 1'b0, 1'b1, 1'b1};
        rst_n     = 1'b0;
        in_valid  = 3'b000;
        in_bit    = 3'b000;
        in_last   = 3'b000;
        sym_ready = 3'b111;
        do_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid", 32'(sym_valid[d]), 32'd0);
            chk("rst_sym", 32'(sym_all[2*d +: 2]), 32'd0);
            chk("rst_last", 32'(sym_last[d]), 32'd0);
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_ready", 32'(in_ready[d]), 32'd1);
        end

        // frame 1,0,1,1 with fixed expected symbols, no backpressure
        @(negedge clk);
        for (int i = 0; i < 4; i++) fbits[i] = f1[i];
        nexp = 6;
        for (int i = 0; i < 6; i++) exp_sym[i] = s1[i];
        run_frame(0, 4, 1'b1, 100, 100);

        // ten zeros: twelve all-zero symbols
        @(negedge clk);
        for (int i = 0; i < 10; i++) fbits[i] = 1'b0;
        nexp = 12;
        for (int i = 0; i < 12; i++) exp_sym[i] = 2'b00;
        run_frame(0, 10, 1'b1, 100, 100);

        // same frame as the first, with random backpressure
        @(negedge clk);
        for (int i = 0; i < 4; i++) fbits[i] = f1[i];
        nexp = 6;
        for (int i = 0; i < 6; i++) exp_sym[i] = s1[i];
        run_frame(0, 4, 1'b1, 50, 100);

        // no tail: frame 1,1 then frame 1
        @(negedge clk);
        fbits[0] = 1'b1;
        fbits[1] = 1'b1;
        nexp = 2;
        exp_sym[0] = 2'b11;
        exp_sym[1] = 2'b01;
        run_frame(1, 2, 1'b0, 100, 100);
        nexp = 1;
        exp_sym[0] = 2'b11;
        run_frame(1, 1, 1'b0, 100, 100);

        // reset right after the first tail symbol appears
        @(negedge clk);
        sym_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid[0] = 1'b1;
            in_bit[0]   = f1[i];
            in_last[0]  = (i == 3);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("tail1_sym", 32'(sym_all[1:0]), 32'(s1[4]));
        chk("tail1_ready", 32'(in_ready[0]), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_valid", 32'(sym_valid[0]), 32'd0);
        chk("midrst_ready", 32'(in_ready[0]), 32'd1);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        fbits[0] = 1'b1;
        build_exp(1, 3, 7, 5, 1'b1);
        chk("model_first_sym", 32'(exp_sym[0]), 32'd3);
        run_frame(0, 1, 1'b1, 100, 100);

        // randomized 1000-bit frames on the K=7 encoder
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 1000; i++) fbits[i] = 1'($urandom_range(1));
            build_exp(1000, 7, 'o171, 'o133, 1'b1);
            run_frame(2, 1000, 1'b1, 70, 80);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
